// File: rtl/seq_divider_ctrl.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// start/busy handshake, registered results and a divide-by-zero flag.
module seq_divider_ctrl #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] shreg;
  logic [BITS-1:0] dvsr;
  logic [BITS-1:0] prem;

  logic [BITS:0]   p;
  logic [BITS:0]   p_diff;
  logic            q_bit;
  logic [BITS-1:0] rem_nxt;
  logic [BITS-1:0] shreg_nxt;

  // One restoring step; p is one bit wider so the trial subtraction never truncates.
  always_comb begin
    p         = {prem, shreg[BITS-1]};
    p_diff    = p - {1'b0, dvsr};
    q_bit     = (p >= {1'b0, dvsr});
    rem_nxt   = q_bit ? p_diff[BITS-1:0] : p[BITS-1:0];
    shreg_nxt = {shreg[BITS-2:0], q_bit};
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      shreg       <= '0;
      dvsr        <= '0;
      prem        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // busy/done are flops that track the upcoming state, keeping them glitch-free.
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              shreg <= dividend;
              dvsr  <= divisor;
              prem  <= '0;
              cnt   <= CW'(BITS - 1);
            end
          end
        end
        RUN: begin
          shreg <= shreg_nxt;
          prem  <= rem_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            quotient    <= shreg_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed and exhaustive self-checking bench for seq_divider_ctrl (BITS=4).
module tb_seq_divider_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [3:0] prev_q = '0;
  logic [3:0] prev_r = '0;

  seq_divider_ctrl #(.BITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the accepting edge; lat counts edges after E0, -1 on timeout.
  task automatic wait_done(input int max, output int lat);
    lat = -1;
    if (done === 1'b1) begin
      lat = 0;
    end else begin
      for (int i = 1; i <= max; i++) begin
        tick();
        if (done === 1'b1) begin
          lat = i;
          break;
        end
        check("hold_quotient", quotient, prev_q);
        check("hold_remainder", remainder, prev_r);
      end
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic ez, input int elat);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    wait_done(10, lat);
    check("latency", lat, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    check("busy_in_done", busy, 1);
    prev_q = eq;
    prev_r = er;
    tick();
    check("done_one_cycle", done, 0);
    check("busy_back_idle", busy, 0);
    check("quotient_held", quotient, eq);
    check("remainder_held", remainder, er);
  endtask

  initial begin
    int lat;
    int d0;
    int cyc;
    bit first;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    run_op(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4);
    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
    run_op(4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 4);
    run_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 0);
    run_op(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 4);

    // Start pulse during RUN is ignored; operand changes after E0 do not matter.
    d0       = done_cnt;
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start    = 1'b1;
    dividend = 4'd8;
    divisor  = 4'd2;
    tick();
    start    = 1'b0;
    dividend = 4'd1;
    divisor  = 4'd1;
    check("busy_mid_run", busy, 1);
    wait_done(10, lat);
    check("busy_test_latency", lat, 2);
    check("busy_test_quotient", quotient, 3);
    check("busy_test_remainder", remainder, 1);
    prev_q = 4'd3;
    prev_r = 4'd1;
    repeat (8) tick();
    check("busy_test_done_count", done_cnt - d0, 1);
    check("busy_test_idle", busy, 0);

    // Reset at E2 aborts the operation silently.
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    d0    = done_cnt;
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    repeat (6) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);
    prev_q = '0;
    prev_r = '0;
    run_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4);

    // All operand pairs back to back with start held high.
    d0    = done_cnt;
    first = 1'b1;
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        dividend = 4'(a);
        divisor  = 4'(b);
        cyc      = 0;
        do begin
          tick();
          cyc++;
        end while (done !== 1'b1 && cyc <= 10);
        if (done !== 1'b1) begin
          check("exh_timeout", done, 1);
        end else begin
          if (!first) check("exh_spacing", cyc, (b == 0) ? 2 : 6);
          check("exh_quotient", quotient, (b == 0) ? 15 : a / b);
          check("exh_remainder", remainder, (b == 0) ? a : a % b);
          check("exh_div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        end
        first = 1'b0;
      end
    end
    start = 1'b0;
    tick();
    tick();
    check("exh_done_count", done_cnt - d0, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_ctrl.md
Name: seq_divider_ctrl

Overview:
Multi-cycle controller that computes an unsigned quotient and remainder with one restoring-division step per clock, MSB first. It replaces the fully unrolled combinational divider chain when area or timing matters. It accepts one operation at a time through a start/busy handshake, registers the results, and flags divide-by-zero. Intended consumer: the calculator front-end, driving start from its divide button.

Parameters:
BITS, 4, operand width; dividend, divisor, quotient and remainder are all BITS wide; BITS >= 2.

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
start  input  1  request; sampled only in IDLE
dividend  input  BITS  unsigned dividend; captured on the accepting edge
divisor  input  BITS  unsigned divisor; captured on the accepting edge
busy  output  1  high in RUN and DONE; start is ignored while high
done  output  1  one-cycle pulse: quotient, remainder and div_by_zero are valid and newly updated
quotient  output  BITS  registered quotient; holds until the next DONE
remainder  output  BITS  registered remainder; holds until the next DONE
div_by_zero  output  1  registered; set with the result of a zero-divisor operation, cleared with any other result

Behaviour:
- Reset: when rst_n is low at a clock edge, state goes to IDLE and the step counter clears. busy, done, quotient, remainder and div_by_zero all go to 0. Reset in any state, including mid-RUN, aborts the operation with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered; no combinational path from inputs to outputs.
- IDLE, start=1, divisor!=0 (edge E0):
  - latch dividend into the shift register and divisor into the divisor register;
  - clear the partial remainder and set the counter to BITS-1;
  - go to RUN.
- IDLE, start=1, divisor==0 (edge E0):
  - go directly to DONE;
  - load quotient to all ones, remainder to the dividend, div_by_zero to 1.
- RUN, each edge E1..E_BITS, one step:
  - p = {partial_rem, MSB of shift register}, computed BITS+1 bits wide so nothing is truncated;
  - if p >= divisor: partial_rem = p - divisor and the quotient bit = 1;
  - else: partial_rem = p[BITS-1:0] and the quotient bit = 0;
  - shift the quotient bit into the LSB of the shift register (dividend bits shift out as quotient bits shift in), then decrement the counter.
- RUN exit: on the edge where the counter is 0, go to DONE and load the quotient, remainder and div_by_zero=0 output registers.
- Outputs during RUN: quotient and remainder keep their previous values until that edge.
- DONE: done=1 and busy=1 for exactly one cycle; go to IDLE on the next edge. start in DONE is ignored.
- Latency, normal operation: start accepted at E0; done is high between edges E_BITS and E_BITS+1. For BITS=4, done is visible after 4 edges.
- Latency, divide by zero: done is high between E0 and E1.
- Throughput: the earliest next accept is E_BITS+2 (normal) or E2 (zero divisor).
- Operand changes: dividend and divisor may change freely after E0 without affecting the operation in flight.
- start held high continuously: a new operation is accepted on each return to IDLE; there is no edge detection inside this block.
- Arithmetic invariant, for divisor!=0: quotient*divisor + remainder == dividend and remainder < divisor, for all operands, including dividend=0, dividend<divisor, and divisor=1.

Test Plan:
- BITS=4, start with dividend=13, divisor=4 -> busy rises after E0; done pulses one cycle after E4; quotient=3, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=7, divisor=9 -> quotient=0, remainder=7. Each result holds stable until the next done.
- dividend=9, divisor=0 -> done after E0 only; quotient=15, remainder=9, div_by_zero=1. The next normal operation, 6/3, gives quotient=2, remainder=0 and clears div_by_zero.
- Busy and operand-change checks:
  - start 13/4, then pulse start with 8/2 at E2 -> ignored; only one done, with result 3,1;
  - change the operands to 1/1 after E0 -> result is still 3,1.
- Reset mid-operation: start 14/3, drive rst_n low at E2 for one edge -> no done; all outputs 0; state IDLE. A following start 14/3 gives quotient=4, remainder=2.
- Exhaustive: all 256 dividend/divisor pairs, back-to-back with start held high -> every result matches a reference model. Zero-divisor cases match the rule above. done count equals operation count, and spacing is 6 cycles (normal) or 2 cycles (zero divisor).
